led_pattern_engine: RTL and testbench
=====================================

// Module: led_pattern_engine
// PURPOSE
//   Parametrised LED pattern generator, single-clock successor to the 4-mode LED demo.
//   Produces one of four patterns on LED_W LEDs at one of four step rates.
//   Step rates come from an internal clock-enable prescaler: no derived or gated clocks.
//   Sits between the board switches (sw, mode) and the LED pins.
// PARAMETERS
//   LED_W    8           LED count; must be even and >= 4
//   CLK_HZ   50_000_000  clk_50 frequency in Hz
//   BASE_HZ  1           slowest step rate in Hz; CLK_HZ must be divisible by 8*BASE_HZ
// PORTS
//   clk_50  in   1      system clock; the only clock in the block
//   rst     in   1      asynchronous, active-low reset
//   sw      in   2      rate select: step rate = BASE_HZ << sw
//   mode    in   2      pattern: 0 RUN, 1 BOUNCE, 2 FILL, 3 SPLIT
//   pause   in   1      freeze pattern; port exists only with LED_PAUSE_EN
//   led     out  LED_W  registered pattern output
//   tick    out  1      registered; high for exactly the cycle in which led first shows a stepped value
// BEHAVIOUR
//   Scope and timing
//   - sw, mode and pause are synchronous to clk_50; synchronising them is done upstream.
//   - Step period P = CLK_HZ/(BASE_HZ<<sw) cycles.
//   - Prescaler: cnt counts 0..P-1. The edge where cnt==P-1 is a step edge:
//     cnt<=0, led<=next(led), tick<=1. On every other edge tick<=0.
//   Reset (rst low, async)
//   - led=0, tick=0, cnt=0, mode_q=0, sw_q=0, dir=up, init_q=1.
//   Restart
//   - Triggered by init_q==1 or mode!=mode_q.
//   - On that edge: led<=START(mode), cnt<=0, mode_q<=mode, dir<=up, init_q<=0, tick<=0.
//   - Restart has priority over a step in the same cycle; no advance occurs.
//   Rate change
//   - sw!=sw_q: cnt<=0, sw_q<=sw, led held, tick<=0.
//   - Next step comes P(new) cycles later. A restart on the same edge also applies.
//   Patterns: START value, then next()
//   - RUN: START 0..01. One-hot rotate left; MSB wraps to LSB.
//   - BOUNCE: START 0..01, dir=up.
//     One-hot moves toward MSB. Reaching MSB sets dir=down; reaching LSB sets dir=up.
//     End positions are shown for one step only (period 2*LED_W-2 steps).
//   - FILL: START 0. next = {led[W-2:0],1'b1}. All-ones steps to 0 (LED_W+1 states).
//   - SPLIT: START {hi=all ones, lo=0}, each LED_W/2 bits wide.
//     On each step lo increments, hi decrements, both wrapping mod 2^(LED_W/2).
//   - All arithmetic is modulo the field width; no output bit outside LED_W is ever driven.
// CONFIGURATION
//   LED_PAUSE_EN defined
//   - pause port present.
//   - While pause=1: cnt and led hold and tick=0.
//   - Restart and rate change still act while paused; the step count resumes from the held cnt.
//   LED_PAUSE_EN undefined
//   - No pause port; the prescaler free-runs.
// TESTING (LED_W=8, CLK_HZ=16, BASE_HZ=1 -> P = 16/8/4/2 for sw = 0/1/2/3)
//   1. Release rst with mode=0, sw=3
//      -> first edge: led=01, tick=0.
//      -> then led 02,04,...,80,01 every 2 cycles, tick high 1 cycle per step.
//   2. mode=1, sw=2, from restart
//      -> every 4 cycles: 01,02,...,80,40,...,02,01,02; 80 and 01 each shown one step.
//   3. mode=2, sw=1
//      -> every 8 cycles: 00,01,03,07,0F,1F,3F,7F,FF,00.
//   4. mode=3, sw=0
//      -> every 16 cycles: F0,E1,D2,...; back to F0 after 16 steps.
//   5. Change mode 0->2 on a step edge
//      -> led=00 on that edge, no tick; next step P cycles later.
//   6. Change sw 3->0 mid-period
//      -> led held; next step exactly 16 cycles after the change edge.
//   7. Assert rst mid-pattern without a clock edge
//      -> led=00 and tick=0 immediately.
//   8. With LED_PAUSE_EN: pause=1 for 10 cycles
//      -> led and cnt frozen; the step lands 10 cycles later than unpaused.

Source files
------------

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: LED pattern generator with an internal clock-enable prescaler.
// Four patterns (RUN, BOUNCE, FILL, SPLIT) at four step rates, all in the clk_50 domain.
//
// Optional feature macro: LED_PAUSE_EN (adds the pause input that freezes the pattern).
//
// Ports:
//   clk_50  in   1      system clock, the only clock in the block
//   rst     in   1      asynchronous active-low reset
//   sw      in   2      rate select, step rate = BASE_HZ << sw
//   mode    in   2      pattern: 0 RUN, 1 BOUNCE, 2 FILL, 3 SPLIT
//   pause   in   1      freeze pattern and prescaler (only with LED_PAUSE_EN)
//   led     out  LED_W  registered pattern
//   tick    out  1      registered, high in the cycle led first shows a stepped value
module led_pattern_engine #(
  parameter int unsigned LED_W   = 8,
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BASE_HZ = 1
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic [1:0]       sw,
  input  logic [1:0]       mode,
`ifdef LED_PAUSE_EN
  input  logic             pause,
`endif
  output logic [LED_W-1:0] led,
  output logic             tick
);

  localparam int unsigned Half = LED_W / 2;
  localparam int unsigned P0   = CLK_HZ / BASE_HZ;
  localparam int unsigned CntW = (P0 > 1) ? $clog2(P0) : 1;

  // Terminal counts for the four rates; sw doubles the rate per step.
  localparam logic [CntW-1:0] Last0 = CntW'(P0 - 1);
  localparam logic [CntW-1:0] Last1 = CntW'(P0 / 2 - 1);
  localparam logic [CntW-1:0] Last2 = CntW'(P0 / 4 - 1);
  localparam logic [CntW-1:0] Last3 = CntW'(P0 / 8 - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  localparam logic [LED_W-1:0] LedOne   = LED_W'(1);
  localparam logic [Half-1:0]  HalfOne  = Half'(1);
  localparam logic [LED_W-1:0] SplitStart = {{Half{1'b1}}, {Half{1'b0}}};

  localparam logic [1:0] ModeRun    = 2'd0;
  localparam logic [1:0] ModeBounce = 2'd1;
  localparam logic [1:0] ModeFill   = 2'd2;
  localparam logic [1:0] ModeSplit  = 2'd3;

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [LED_W-1:0] led_q, led_d;
  logic             tick_q, tick_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       sw_q, sw_d;
  dir_e             dir_q, dir_d;
  logic             init_q, init_d;

  logic [LED_W-1:0] step_led;
  dir_e             step_dir;
  logic [LED_W-1:0] start_led;
  logic [CntW-1:0]  cnt_last;
  logic             hold;

`ifdef LED_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      led_q  <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= 2'd0;
      sw_q   <= 2'd0;
      dir_q  <= DirUp;
      init_q <= 1'b1;
    end else begin
      led_q  <= led_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      sw_q   <= sw_d;
      dir_q  <= dir_d;
      init_q <= init_d;
    end
  end

  // Pattern advance for the current mode, plus the start value of the requested mode.
  always_comb begin
    step_led = led_q;
    step_dir = dir_q;
    unique case (mode_q)
      ModeRun: step_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
      ModeBounce: begin
        if (dir_q == DirUp) begin
          step_led = led_q << 1;
          if (step_led[LED_W-1]) step_dir = DirDown;
        end else begin
          step_led = led_q >> 1;
          if (step_led[0]) step_dir = DirUp;
        end
      end
      ModeFill: step_led = (&led_q) ? '0 : {led_q[LED_W-2:0], 1'b1};
      ModeSplit: step_led = {led_q[LED_W-1:Half] - HalfOne, led_q[Half-1:0] + HalfOne};
    endcase

    start_led = '0;
    unique case (mode)
      ModeRun, ModeBounce: start_led = LedOne;
      ModeFill:            start_led = '0;
      ModeSplit:           start_led = SplitStart;
    endcase

    cnt_last = Last0;
    unique case (sw_q)
      2'd0: cnt_last = Last0;
      2'd1: cnt_last = Last1;
      2'd2: cnt_last = Last2;
      2'd3: cnt_last = Last3;
    endcase
  end

  // Next state: restart beats rate change beats pause beats step.
  always_comb begin
    led_d  = led_q;
    tick_d = 1'b0;
    cnt_d  = cnt_q + CntOne;
    mode_d = mode_q;
    sw_d   = sw_q;
    dir_d  = dir_q;
    init_d = init_q;

    if (init_q || (mode != mode_q)) begin
      led_d  = start_led;
      cnt_d  = '0;
      mode_d = mode;
      dir_d  = DirUp;
      init_d = 1'b0;
      sw_d   = sw;  // a simultaneous rate change also lands
    end else if (sw != sw_q) begin
      cnt_d = '0;
      sw_d  = sw;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (cnt_q == cnt_last) begin
      cnt_d  = '0;
      led_d  = step_led;
      dir_d  = step_dir;
      tick_d = 1'b1;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    led  = led_q;
    tick = tick_q;
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;

  localparam int W      = 8;
  localparam int CLK_HZ = 16;

  logic       clk_50 = 1'b0;
  logic       rst    = 1'b0;
  logic [1:0] sw     = 2'd3;
  logic [1:0] mode   = 2'd0;
  logic       pause  = 1'b0;
  logic [W-1:0] led;
  logic       tick;

  always #5 clk_50 = ~clk_50;

  led_pattern_engine #(
    .LED_W  (W),
    .CLK_HZ (CLK_HZ),
    .BASE_HZ(1)
  ) dut (
    .clk_50(clk_50),
    .rst   (rst),
    .sw    (sw),
    .mode  (mode),
`ifdef LED_PAUSE_EN
    .pause (pause),
`endif
    .led   (led),
    .tick  (tick)
  );

  typedef struct {
    logic [W-1:0] led;
    logic         tick;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  // Reference model: step index since restart plus cycles elapsed in the current period.
  bit         m_init;
  logic [1:0] m_mode, m_sw;
  int         m_cnt, m_k;

  function automatic int period(input logic [1:0] s);
    return CLK_HZ >> s;
  endfunction

  function automatic logic [W-1:0] pattern(input logic [1:0] md, input int k);
    int pos;
    logic [W-1:0] r;
    case (md)
      2'd0: r = 8'(1 << (k % W));
      2'd1: begin
        pos = k % (2 * W - 2);
        r = (pos < W) ? 8'(1 << pos) : 8'(1 << (2 * W - 2 - pos));
      end
      2'd2: begin
        pos = k % (W + 1);
        r = 8'((1 << pos) - 1);
      end
      default: r = {4'(15 - (k % 16)), 4'(k % 16)};
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_init = 1'b1;
    m_mode = 2'd0;
    m_sw   = 2'd0;
    m_cnt  = 0;
    m_k    = 0;
  endtask

  // Predict the state after the coming posedge from the inputs now applied.
  task automatic model_apply();
    exp_t e;
    bit   p;
`ifdef LED_PAUSE_EN
    p = pause;
`else
    p = 1'b0;
`endif
    e.tick = 1'b0;
    if (m_init || mode != m_mode) begin
      m_init = 1'b0;
      m_mode = mode;
      m_k    = 0;
      m_cnt  = 0;
      m_sw   = sw;
    end else if (sw != m_sw) begin
      m_sw  = sw;
      m_cnt = 0;
    end else if (p) begin
      // hold
    end else if (m_cnt == period(m_sw) - 1) begin
      m_cnt  = 0;
      m_k    = m_k + 1;
      e.tick = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    e.led = pattern(m_mode, m_k);
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] md, input logic [1:0] s, input logic p);
    @(negedge clk_50);
    mode  = md;
    sw    = s;
    pause = p;
    model_apply();
  endtask

  task automatic check_now(input string name, input logic [W-1:0] exp_led,
                           input logic exp_tick);
    checks++;
    if (led !== exp_led || tick !== exp_tick) begin
      failures++;
      $display("FAIL %s: got led=%h tick=%b, expected led=%h tick=%b",
               name, led, tick, exp_led, exp_tick);
    end
  endtask

  // Monitor: DUT presents a new output every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_50);
      #1;
      if (mon_en) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got led=%h tick=%b, expected a queued entry", led, tick);
        end else begin
          e = sb_q.pop_front();
          check_now("cycle", e.led, e.tick);
        end
      end
    end
  end

  task automatic release_reset();
    @(negedge clk_50);
    rst = 1'b1;
    model_reset();
    model_apply();
    mon_en = 1'b1;
  endtask

  task automatic mid_reset();
    exp_t z;
    z.led  = '0;
    z.tick = 1'b0;
    @(negedge clk_50);
    #2;
    rst = 1'b0;
    #1;
    check_now("async_reset", '0, 1'b0);
    sb_q.push_back(z);
    repeat (2) begin
      @(negedge clk_50);
      sb_q.push_back(z);
    end
    release_reset();
  endtask

  initial begin
    logic [1:0] md, s;
    int len, pause_left;

    // Reset state before any edge is released.
    repeat (3) @(negedge clk_50);
    check_now("reset_state", '0, 1'b0);
    release_reset();

    // Directed: the four patterns at the four rates.
    repeat (40)  drive(2'd0, 2'd3, 1'b0);
    repeat (80)  drive(2'd1, 2'd2, 1'b0);
    repeat (100) drive(2'd2, 2'd1, 1'b0);
    repeat (300) drive(2'd3, 2'd0, 1'b0);

    // Mode change landing exactly on a step edge.
    for (int i = 0; i < 20 && m_cnt != period(m_sw) - 1; i++) drive(2'd0, 2'd3, 1'b0);
    drive(2'd2, 2'd3, 1'b0);
    repeat (10) drive(2'd2, 2'd3, 1'b0);

    // Rate change mid-period.
    drive(2'd2, 2'd3, 1'b0);
    repeat (40) drive(2'd2, 2'd0, 1'b0);

    // Randomised phases with occasional rate flips and pause bursts.
    pause_left = 0;
    for (int ph = 0; ph < 30; ph++) begin
      md  = 2'($urandom % 4);
      s   = 2'($urandom % 4);
      len = $urandom_range(10, 150);
      if ($urandom % 2 == 0) begin
        for (int i = 0; i < 20 && m_cnt != period(m_sw) - 1; i++) drive(mode, sw, 1'b0);
      end
      for (int c = 0; c < len; c++) begin
        if ($urandom % 40 == 0) s = 2'($urandom % 4);
        if (pause_left == 0 && $urandom % 30 == 0) pause_left = $urandom_range(1, 12);
        drive(md, s, pause_left > 0);
        if (pause_left > 0) pause_left--;
      end
      if (ph == 15) mid_reset();
    end

    drive(mode, sw, 1'b0);
    @(posedge clk_50);
    #2;
    mon_en = 1'b0;
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
